// File: rtl/packet_skid_rx_pkg.sv
// Shared defaults for the packet receive slice.
package packet_skid_rx_pkg;

    localparam int PSR_DW_DEF    = 104;
    localparam int PSR_CW_DEF    = 32;
    localparam bit PSR_CHECK_DEF = 1'b1;

endpackage

// File: rtl/packet_skid_rx_proto_check.sv
// Producer protocol checker: once a beat is stalled, the producer must keep
// access high and the packet unchanged until it is accepted. Sticky error.
module packet_proto_check
    import packet_skid_rx_pkg::*;
#(
    parameter int DW = PSR_DW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr_stats,
    input  logic          access_in,
    input  logic [DW-1:0] packet_in,
    input  logic          wait_out,
    output logic          proto_err
);

    logic          stall_q, stall_d;
    logic [DW-1:0] pkt_q, pkt_d;
    logic          err_q, err_d;
    logic          viol;

    // Capture the stalled beat and flag any change to it on the following cycle.
    always_comb begin
        stall_d = access_in & wait_out;
        pkt_d   = packet_in;
        viol    = stall_q & (~access_in | (packet_in != pkt_q));
        err_d   = err_q | viol;
        if (clr_stats) err_d = 1'b0;
    end

    // Control flops reset; the packet snapshot does not need to.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            stall_q <= stall_d;
            err_q   <= err_d;
        end
    end

    // Packet snapshot, only meaningful while stall_q is set.
    always_ff @(posedge clk) begin
        pkt_q <= pkt_d;
    end

    assign proto_err = err_q;

endmodule

// File: rtl/packet_skid_rx.sv
// Receive slice: main + skid entry so wait_out is a pure flop output, with an
// accepted-packet counter and an optional producer protocol checker.
module packet_skid_rx
    import packet_skid_rx_pkg::*;
#(
    parameter int DW    = PSR_DW_DEF,
    parameter int CW    = PSR_CW_DEF,
    parameter bit CHECK = PSR_CHECK_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          access_in,
    input  logic [DW-1:0] packet_in,
    output logic          wait_out,
    output logic          access_out,
    output logic [DW-1:0] packet_out,
    input  logic          wait_in,
    input  logic          clr_stats,
    output logic [CW-1:0] pkt_count,
    output logic          proto_err
);

    logic          main_valid_q, main_valid_d;
    logic          skid_valid_q, skid_valid_d;
    logic [DW-1:0] main_data_q, main_data_d;
    logic [DW-1:0] skid_data_q, skid_data_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          in_xfer, out_xfer;

    // Skid control: fill main first, spill to skid only when main cannot drain.
    always_comb begin
        in_xfer      = access_in & ~skid_valid_q;
        out_xfer     = main_valid_q & ~wait_in;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        main_data_d  = main_data_q;
        skid_data_d  = skid_data_q;
        if (in_xfer && (!main_valid_q || out_xfer)) begin
            main_data_d  = packet_in;
            main_valid_d = 1'b1;
        end else if (in_xfer) begin
            skid_data_d  = packet_in;
            skid_valid_d = 1'b1;
        end else if (out_xfer && skid_valid_q) begin
            main_data_d  = skid_data_q;
            skid_valid_d = 1'b0;
        end else if (out_xfer) begin
            main_valid_d = 1'b0;
        end
    end

    // Accepted-beat counter; a clear beats a same-cycle increment.
    always_comb begin
        cnt_d = cnt_q;
        if (in_xfer) cnt_d = cnt_q + 1'b1;
        if (clr_stats) cnt_d = '0;
    end

    // Valid bits and counter: reset drops any in-flight packets.
    always_ff @(posedge clk) begin
        if (reset) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            cnt_q        <= cnt_d;
        end
    end

    // Data registers are qualified by the valid bits, so they carry no reset.
    always_ff @(posedge clk) begin
        main_data_q <= main_data_d;
        skid_data_q <= skid_data_d;
    end

    assign wait_out   = skid_valid_q;
    assign access_out = main_valid_q;
    assign packet_out = main_data_q;
    assign pkt_count  = cnt_q;

    generate
        if (CHECK) begin : g_chk
            packet_proto_check #(.DW(DW)) u_chk (
                .clk       (clk),
                .reset     (reset),
                .clr_stats (clr_stats),
                .access_in (access_in),
                .packet_in (packet_in),
                .wait_out  (skid_valid_q),
                .proto_err (proto_err)
            );
        end else begin : g_nochk
            assign proto_err = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_packet_skid_rx.sv
// Scoreboard bench for packet_skid_rx: a 32-bit-count instance with checker and
// a 4-bit-count instance without checker share the same stimulus.
module tb_packet_skid_rx;

    localparam int DW = 104;

    logic          clk = 1'b0;
    logic          reset;
    logic          access_in;
    logic [DW-1:0] packet_in;
    logic          wait_in;
    logic          clr_stats;
    logic          wait_out, access_out, proto_err;
    logic [DW-1:0] packet_out;
    logic [31:0]   pkt_count;
    logic          wait_out4, access_out4, proto_err4;
    logic [DW-1:0] packet_out4;
    logic [3:0]    pkt_count4;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    packet_skid_rx #(.DW(DW), .CW(32), .CHECK(1'b1)) dut (
        .clk(clk), .reset(reset), .access_in(access_in), .packet_in(packet_in),
        .wait_out(wait_out), .access_out(access_out), .packet_out(packet_out),
        .wait_in(wait_in), .clr_stats(clr_stats), .pkt_count(pkt_count),
        .proto_err(proto_err)
    );

    packet_skid_rx #(.DW(DW), .CW(4), .CHECK(1'b0)) dut4 (
        .clk(clk), .reset(reset), .access_in(access_in), .packet_in(packet_in),
        .wait_out(wait_out4), .access_out(access_out4), .packet_out(packet_out4),
        .wait_in(wait_in), .clr_stats(clr_stats), .pkt_count(pkt_count4),
        .proto_err(proto_err4)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model + monitor ----------------
    // The slice is a 2-deep in-order FIFO: valid out when non-empty,
    // push-back when holding two beats.
    logic [DW-1:0] sb[$];
    logic [31:0]   cnt_m    = '0;
    logic          err_m    = 1'b0;
    logic          stall_m  = 1'b0;
    logic [DW-1:0] pkt_m    = '0;
    logic          mon_en   = 1'b0;

    always @(negedge clk) begin
        if (mon_en) begin
            automatic logic exp_acc  = (sb.size() > 0);
            automatic logic exp_wait = (sb.size() >= 2);
            automatic logic in_x     = access_in && !exp_wait;
            automatic logic out_x    = exp_acc && !wait_in;
            automatic logic viol     = stall_m && (!access_in || packet_in != pkt_m);
            chk("access_out", 128'(access_out), 128'(exp_acc));
            chk("wait_out",   128'(wait_out),   128'(exp_wait));
            chk("access_out4", 128'(access_out4), 128'(exp_acc));
            chk("wait_out4",   128'(wait_out4),   128'(exp_wait));
            chk("pkt_count",  128'(pkt_count),  128'(cnt_m));
            chk("pkt_count4", 128'(pkt_count4), 128'(cnt_m[3:0]));
            chk("proto_err",  128'(proto_err),  128'(err_m));
            chk("proto_err4", 128'(proto_err4), 128'(1'b0));
            if (exp_acc) begin
                chk("packet_out",  128'(packet_out),  128'(sb[0]));
                chk("packet_out4", 128'(packet_out4), 128'(sb[0]));
            end
            if (reset) begin
                sb.delete();
                cnt_m   = '0;
                err_m   = 1'b0;
                stall_m = 1'b0;
            end else begin
                if (out_x) void'(sb.pop_front());
                if (in_x) sb.push_back(packet_in);
                if (clr_stats) cnt_m = '0;
                else if (in_x) cnt_m = cnt_m + 1;
                if (clr_stats) err_m = 1'b0;
                else if (viol) err_m = 1'b1;
                stall_m = access_in && exp_wait;
                pkt_m   = packet_in;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input logic a, input logic [DW-1:0] p, input logic w,
                       input logic c, input logic r);
        access_in = a; packet_in = p; wait_in = w; clr_stats = c; reset = r;
        @(posedge clk); #1;
    endtask

    function automatic logic [DW-1:0] rnd_pkt();
        logic [127:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        return r[DW-1:0];
    endfunction

    initial begin
        logic          a, w, c;
        logic [DW-1:0] p;
        a = 1'b0; p = '0;

        // Reset state
        cyc(0, '0, 0, 0, 1);
        cyc(0, '0, 0, 0, 1);
        chk("rst_access_out", 128'(access_out), 128'(0));
        chk("rst_wait_out",   128'(wait_out),   128'(0));
        chk("rst_pkt_count",  128'(pkt_count),  128'(0));
        chk("rst_proto_err",  128'(proto_err),  128'(0));
        mon_en = 1'b1;

        // 1: streaming, no back-pressure
        for (int i = 1; i <= 8; i++) cyc(1, DW'(i), 0, 0, 0);
        chk("t1_first_lat_pkt", 128'(packet_out), 128'(8));
        cyc(0, '0, 0, 0, 0);
        chk("t1_pkt_count", 128'(pkt_count), 128'(8));
        chk("t1_drained", 128'(access_out), 128'(0));

        // 2: downstream stall for 3 cycles fills main + skid
        cyc(1, DW'('h21), 1, 0, 0);
        chk("t2_wait_one_entry", 128'(wait_out), 128'(0));
        cyc(1, DW'('h22), 1, 0, 0);
        chk("t2_wait_full", 128'(wait_out), 128'(1));
        cyc(1, DW'('h23), 1, 0, 0);
        cyc(1, DW'('h23), 0, 0, 0);
        cyc(1, DW'('h23), 0, 0, 0);
        cyc(0, '0, 0, 0, 0);
        cyc(0, '0, 0, 0, 0);
        chk("t2_count", 128'(pkt_count), 128'(11));

        // 4a: producer drops access while stalled
        cyc(1, DW'('hA1), 1, 0, 0);
        cyc(1, DW'('hA2), 1, 0, 0);
        cyc(1, DW'('hA),  1, 0, 0);
        cyc(0, '0, 1, 0, 0);
        chk("t4_drop_err", 128'(proto_err), 128'(1));
        cyc(0, '0, 0, 0, 0);
        cyc(0, '0, 0, 0, 0);
        chk("t4_sticky", 128'(proto_err), 128'(1));
        cyc(0, '0, 0, 1, 0);
        chk("t4_clr", 128'(proto_err), 128'(0));
        // 4b: packet changes while stalled
        cyc(1, DW'('h1), 1, 0, 0);
        cyc(1, DW'('h2), 1, 0, 0);
        cyc(1, DW'('hA), 1, 0, 0);
        cyc(1, DW'('hB), 1, 0, 0);
        chk("t4_change_err", 128'(proto_err), 128'(1));
        cyc(1, DW'('hB), 0, 0, 0);
        cyc(1, DW'('hB), 0, 0, 0);
        cyc(0, '0, 0, 1, 0);
        cyc(0, '0, 0, 0, 0);
        chk("t4_clr2", 128'(proto_err), 128'(0));

        // 5: reset with both entries full, then a clean stream
        cyc(1, DW'('h55), 1, 0, 0);
        cyc(1, DW'('h56), 1, 0, 0);
        chk("t5_full", 128'(wait_out), 128'(1));
        cyc(1, DW'('h57), 1, 0, 1);
        chk("t5_rst_access", 128'(access_out), 128'(0));
        chk("t5_rst_wait",   128'(wait_out),   128'(0));
        chk("t5_rst_count",  128'(pkt_count),  128'(0));
        for (int i = 0; i < 4; i++) cyc(1, DW'('h10 + i), 0, 0, 0);
        cyc(0, '0, 0, 0, 0);
        chk("t5_count", 128'(pkt_count), 128'(4));

        // 6: 4-bit counter wrap and clear-vs-increment
        cyc(0, '0, 0, 1, 0);
        for (int i = 0; i < 17; i++) cyc(1, DW'(i), 0, 0, 0);
        chk("t6_wrap4", 128'(pkt_count4), 128'(1));
        chk("t6_full32", 128'(pkt_count), 128'(17));
        cyc(1, DW'('h99), 0, 1, 0);
        chk("t6_clr_wins4", 128'(pkt_count4), 128'(0));
        chk("t6_clr_wins32", 128'(pkt_count), 128'(0));

        // 3: random traffic from a protocol-compliant producer
        for (int i = 0; i < 10000; i++) begin
            if (!stall_m) begin
                a = ($urandom_range(0, 3) != 0);
                p = rnd_pkt();
            end
            w = (i % 2000 < 300) ? 1'(i & 1) : ($urandom_range(0, 2) == 0);
            c = ($urandom_range(0, 499) == 0);
            cyc(a, p, w, c, 0);
        end
        while (stall_m) cyc(1, p, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, '0, 0, 0, 0);
        chk("t3_drained", 128'(sb.size()), 128'(0));
        chk("t3_no_err", 128'(proto_err), 128'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
